// File: rtl/icache_responder.sv
// icache_responder: direct-mapped instruction cache front end, one 32-bit
// instruction per line, 2^IDX_W lines. Each request takes the path
// IDLE -> LOOKUP -> (MISS_REQ -> MISS_WAIT ->) RESP.
//
// Ports
//   clk, rst              clock (rising edge) and asynchronous active-low reset
//   req_valid_i/addr/wen  fetch request; accepted when req_valid_i && req_ready_o
//   req_ready_o           high only while idle
//   resp_valid_o          one-cycle response strobe carrying resp_data_o/resp_err_o
//   flush_i               invalidate every line at the next edge
//   mem_req_*             refill request handshake toward memory
//   mem_resp_*            refill data return, only honoured while waiting for it
//
// Optional feature: define ICACHE_PERF_CNT_EN to add the 32-bit hit_cnt_o and
// miss_cnt_o lookup counters.
module icache_responder #(
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_wen_i,
    output logic              req_ready_o,
    output logic              resp_valid_o,
    output logic [31:0]       resp_data_o,
    output logic              resp_err_o,
    input  logic              flush_i,
    output logic              mem_req_valid_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_req_ready_i,
    input  logic              mem_resp_valid_i,
    input  logic [31:0]       mem_resp_data_i
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic              fill_kill;
    logic [LINES-1:0]  valid_bits;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [31:0]       data_mem [LINES];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              bad;
    logic              hit;
    logic              fill;

    assign idx  = addr[IDX_W+1:2];
    assign tag  = addr[ADDR_W-1:IDX_W+2];
    assign bad  = (addr[1:0] != 2'b00) || wen;
    assign hit  = valid_bits[idx] && (tag_mem[idx] == tag);
    assign fill = (state == MISS_WAIT) && mem_resp_valid_i;

    // All outputs are registered and move together with the state, so the
    // asynchronous reset drives every one of them (req_ready_o included) to 0.
    // req_ready_o comes back one edge after reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            addr            <= '0;
            wen             <= 1'b0;
            fill_kill       <= 1'b0;
            req_ready_o     <= 1'b0;
            resp_valid_o    <= 1'b0;
            resp_data_o     <= '0;
            resp_err_o      <= 1'b0;
            mem_req_valid_o <= 1'b0;
            mem_req_addr_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        addr        <= req_addr_i;
                        wen         <= req_wen_i;
                        req_ready_o <= 1'b0;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (bad) begin
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b1;
                        resp_data_o  <= '0;
                        state        <= RESP;
                    end else if (hit) begin
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        resp_data_o  <= data_mem[idx];
                        state        <= RESP;
                    end else begin
                        mem_req_valid_o <= 1'b1;
                        mem_req_addr_o  <= addr;
                        fill_kill       <= 1'b0;
                        state           <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    // A flush while the refill is outstanding means the
                    // returning line may be stale: deliver it, don't cache it.
                    if (flush_i) fill_kill <= 1'b1;
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        mem_req_addr_o  <= '0;
                        state           <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (flush_i) fill_kill <= 1'b1;
                    if (mem_resp_valid_i) begin
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        resp_data_o  <= mem_resp_data_i;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_o <= 1'b0;
                    resp_err_o   <= 1'b0;
                    resp_data_o  <= '0;
                    req_ready_o  <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Flush takes priority over a same-edge fill, and over any fill that was
    // already marked stale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_bits <= '0;
        end else if (flush_i) begin
            valid_bits <= '0;
        end else if (fill && !fill_kill) begin
            valid_bits[idx] <= 1'b1;
        end
    end

    // Tag/data storage carries no reset; the valid bits qualify its contents.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= mem_resp_data_i;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Only well-formed lookups are counted; error responses count neither.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (state == LOOKUP && !bad) begin
            if (hit) hit_cnt_o  <= hit_cnt_o + 32'd1;
            else     miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: doc/icache_responder.md
ICACHE_RESPONDER -- requirements
Module: icache_responder

Interface
REQ-001 SHALL have parameter IDX_W, default 4, index width (2^IDX_W direct-mapped lines, one 32-bit instruction per line).
REQ-002 SHALL have parameter ADDR_W, default 64, request address width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid_i  input  1  fetch request valid.
REQ-006 SHALL have port req_addr_i  input  ADDR_W  instruction address.
REQ-007 SHALL have port req_wen_i  input  1  write request; unsupported, answered with error.
REQ-008 SHALL have port req_ready_o  output  1  request accepted when req_valid_i && req_ready_o.
REQ-009 SHALL have port resp_valid_o  output  1  one-cycle response strobe.
REQ-010 SHALL have port resp_data_o  output  32  instruction word.
REQ-011 SHALL have port resp_err_o  output  1  error flag, qualified by resp_valid_o.
REQ-012 SHALL have port flush_i  input  1  invalidate all lines (fence.i).
REQ-013 SHALL have ports mem_req_valid_o (output, 1), mem_req_addr_o (output, ADDR_W), mem_req_ready_i (input, 1): refill request handshake.
REQ-014 SHALL have ports mem_resp_valid_i (input, 1), mem_resp_data_i (input, 32): refill data return.

Function
REQ-015 SHALL decode index = addr[IDX_W+1:2], tag = addr[ADDR_W-1:IDX_W+2].
REQ-016 SHALL implement states IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP; req_ready_o = 1 only in IDLE.
REQ-017 IDLE: accepted request registers addr/wen, goes to LOOKUP.
REQ-018 LOOKUP: addr[1:0]!=0 or wen=1 -> RESP with err=1, data 0, no memory access; valid && tag match -> RESP with hit data; else -> MISS_REQ.
REQ-019 MISS_REQ: mem_req_valid_o=1, mem_req_addr_o = registered addr, held stable until mem_req_ready_i; then MISS_WAIT.
REQ-020 MISS_WAIT: on mem_resp_valid_i, write data/tag, set valid bit, capture data for response, go to RESP.
REQ-021 RESP: resp_valid_o=1 for exactly one cycle, then IDLE; no backpressure from requester.
REQ-022 Hit latency: accept at edge N, resp_valid_o high in cycle N+2; back-to-back hits every 3 cycles.
REQ-023 flush_i in any state SHALL clear all valid bits at next edge.
REQ-024 flush_i during MISS_REQ/MISS_WAIT SHALL suppress the pending line fill; response still carries memory data, err=0.
REQ-025 flush_i with request accepted same cycle: flush applies first; request looks up an empty cache and misses.
REQ-026 resp_data_o/resp_err_o SHALL be 0 whenever resp_valid_o=0.
REQ-027 mem_resp_valid_i outside MISS_WAIT SHALL be ignored.

Reset
REQ-028 rst low SHALL asynchronously force state IDLE, all valid bits 0, and all outputs 0 (including req_ready_o).
REQ-029 Reset mid-miss SHALL abandon the refill; no line written; no response issued.
REQ-030 Tag/data arrays need not be reset.

Configuration
REQ-031 With ICACHE_PERF_CNT_EN defined, SHALL add outputs hit_cnt_o, miss_cnt_o (32-bit, wrap-around, reset 0), incremented on LOOKUP hit/miss (errors count neither).
REQ-032 Without ICACHE_PERF_CNT_EN, those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-033 Cold miss: req 0x80000000, mem returns 0x00000013 after 3 cycles -> one mem_req to 0x80000000, resp data 0x00000013, err 0.
REQ-034 Hit: repeat 0x80000000 -> resp two cycles after accept, no mem_req_valid_o.
REQ-035 Conflict: 0x80000000 then 0x80000040 (same index, IDX_W=4) then 0x80000000 -> three misses.
REQ-036 Error: req 0x80000002 or req_wen_i=1 -> resp err 1, data 0, no mem access.
REQ-037 Flush during MISS_WAIT for 0x80000004 -> response delivered; next req 0x80000004 misses again.
REQ-038 rst low during MISS_REQ -> outputs 0 immediately; after release req_ready_o=1, cache empty.
